// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes and an iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_to_alu_a,
    input  logic [DATA_W-1:0] io_to_alu_b,
    input  logic [3:0]        io_alu_op,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_result,
    input  logic              io_flush,
    output logic              io_busy
);

    localparam int SHAMT_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    res, res_nxt;
    logic [SHAMT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]           op_q, op_nxt;
    logic                 accept;

    // Single-cycle result. Without the barrel shifter, shift ops only land here with amount 0.
    function automatic logic [DATA_W-1:0] alu_calc(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [3:0]        op);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
`ifdef ALU_FAST_SHIFT_EN
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
`endif
        sa = a;
        sb = b;
        case (op)
            OP_ADD:   alu_calc = a + b;
            OP_SUB:   alu_calc = a - b;
            OP_AND:   alu_calc = a & b;
            OP_OR:    alu_calc = a | b;
            OP_XOR:   alu_calc = a ^ b;
            OP_SLT:   alu_calc = {{(DATA_W-1){1'b0}}, (sa < sb)};
            OP_SLTU:  alu_calc = {{(DATA_W-1){1'b0}}, (a < b)};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:   alu_calc = a << sh;
            OP_SRL:   alu_calc = a >> sh;
            OP_SRA:   alu_calc = $unsigned(sa >>> sh);
`else
            OP_SLL:   alu_calc = a;
            OP_SRL:   alu_calc = a;
            OP_SRA:   alu_calc = a;
`endif
            OP_PASSB: alu_calc = b;
            default:  alu_calc = '0;
        endcase
    endfunction

    // One iteration of the serial shifter; SRA keeps copying the original sign bit.
    function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] v,
                                                     input logic [3:0]        op);
        case (op)
            OP_SLL:  shift_step = {v[DATA_W-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, v[DATA_W-1:1]};
            OP_SRA:  shift_step = {v[DATA_W-1], v[DATA_W-1:1]};
            default: shift_step = v;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            res   <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            res   <= res_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        res_nxt     = res;
        cnt_nxt     = cnt;
        op_nxt      = op_q;
        io_in_ready = (state == IDLE) || ((state == DONE) && io_out_ready);
        accept      = io_in_valid && io_in_ready && !io_flush;

        case (state)
            SHIFT: begin
                res_nxt = shift_step(res, op_q);
                cnt_nxt = cnt - 1'b1;
                if (cnt == SHAMT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (io_out_ready)
                    state_nxt = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            op_nxt    = io_alu_op;
            state_nxt = DONE;
            res_nxt   = alu_calc(io_to_alu_a, io_to_alu_b, io_alu_op);
`ifndef ALU_FAST_SHIFT_EN
            if ((io_alu_op == OP_SLL || io_alu_op == OP_SRL || io_alu_op == OP_SRA) &&
                (io_to_alu_b[SHAMT_W-1:0] != '0)) begin
                state_nxt = SHIFT;
                res_nxt   = io_to_alu_a;
                cnt_nxt   = io_to_alu_b[SHAMT_W-1:0];
            end
`endif
        end

        // Kill wins over completion, handshake and new accepts alike.
        if (io_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    assign io_out_valid  = (state == DONE);
    assign io_out_result = res;
`ifdef ALU_FAST_SHIFT_EN
    assign io_busy = 1'b0;
`else
    assign io_busy = (state == SHIFT);
`endif

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising-edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: io_to_alu_a  in  32  operand A from the rs1/PC selection.
REQ-004 SHALL have: io_to_alu_b  in  32  operand B from the rs2/imm/PC operand mux.
REQ-005 SHALL have: io_alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB, 11-15 reserved.
REQ-006 SHALL have: io_in_valid  in  1, and io_in_ready  out  1: operand handshake.
REQ-007 SHALL have: io_out_valid  out  1, io_out_ready  in  1, io_out_result  out  32: result handshake.
REQ-008 SHALL have: io_flush  in  1  synchronous pipeline kill.
REQ-009 SHALL have: io_busy  out  1  high while in SHIFT state.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL assert io_in_ready in IDLE, or in DONE while io_out_ready=1; low in SHIFT.
REQ-012 SHALL accept an operation on a rising edge with io_in_valid=1 and io_in_ready=1, latching A, B, op.
REQ-013 Non-shift ops SHALL go to DONE with the result registered; io_out_valid high the cycle after acceptance (latency 1).
REQ-014 ADD/SUB SHALL wrap modulo 2^32; SLT signed, SLTU unsigned compare, result 32'h1 or 32'h0; PASSB returns B.
REQ-015 Reserved ops SHALL complete with latency 1 and result 32'h0.
REQ-016 Shift amount SHALL be B[4:0]; B[31:5] ignored.
REQ-017 Shift with amount 0 SHALL go directly to DONE, result = A, latency 1.
REQ-018 Shift with amount n>0 SHALL enter SHIFT, shift one bit per cycle, down-count a 5-bit counter, enter DONE after n cycles: latency n+1.
REQ-019 SRA SHALL replicate A[31] into vacated bits each step; SRL/SLL fill zeros.
REQ-020 In DONE, io_out_result and io_out_valid SHALL hold stable until io_out_ready=1.
REQ-021 DONE with io_out_ready=1 and no new accept SHALL go to IDLE, io_out_valid low next cycle.
REQ-022 DONE with io_out_ready=1 and simultaneous accept SHALL start the new op with no bubble (back-to-back throughput 1/cycle for non-shift ops).
REQ-023 io_flush=1 SHALL have priority over all: next state IDLE, io_out_valid=0, counter cleared, no operation accepted that edge.
REQ-024 io_in_valid during SHIFT SHALL be ignored (not accepted, no state change).

Reset
REQ-025 Reset low SHALL immediately force state IDLE, io_out_valid=0, io_out_result=32'h0, io_busy=0, counter=0, independent of clock.
REQ-026 Reset asserted mid-SHIFT SHALL abandon the operation; no result issued after release.
REQ-027 After reset release, io_in_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 Macro ALU_FAST_SHIFT_EN defined: SLL/SRL/SRA SHALL use a single-cycle barrel shifter, latency 1, SHIFT state never entered, io_busy constant 0.
REQ-029 Macro ALU_FAST_SHIFT_EN undefined: iterative shifting per REQ-017..019.

Verification
REQ-030 ADD A=32'hFFFFFFFF, B=32'h1, out_ready=1 -> next cycle out_valid=1, result 32'h0.
REQ-031 SLT A=32'h80000000, B=32'h1 -> 32'h1; SLTU same operands -> 32'h0.
REQ-032 SRA A=32'hF0000000, B=32'h24 (amount 4) -> io_busy high 4 cycles, out_valid on 5th cycle, result 32'hFF000000; FAST_SHIFT_EN build -> 1 cycle.
REQ-033 SUB A=5, B=7 with out_ready=0 for 3 cycles -> result 32'hFFFFFFFE held stable, in_ready=0 until out_ready=1.
REQ-034 SLL A=1, B=31, flush asserted on 3rd SHIFT cycle -> state IDLE next cycle, out_valid never asserts, in_ready=1.
REQ-035 Four back-to-back ADDs with out_ready=1 -> four results on four consecutive cycles; reset pulse mid-stream -> out_valid=0 immediately.
